// File: rtl/sw_pkg.sv
// Shared types and constants for the 3x3 sliding-window generator.
package sw_pkg;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_e;

    localparam int IMG_W_DEF = 64;
    localparam int IMG_H_DEF = 64;
    localparam int COL_W     = $clog2(IMG_W_DEF);
    localparam int ROW_W     = $clog2(IMG_H_DEF);

    // Row-major window positions: top-left, centre, bottom-right.
    localparam int TL = 1;
    localparam int C  = 5;
    localparam int BR = 9;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sliding_window_gen_if.sv
// Pixel-in / window-out handshake bundle of the sliding-window generator.
interface sliding_window_gen_if #(
    parameter int PIX_W = 8
);
    logic             in_valid;
    logic             in_sof;
    logic [PIX_W-1:0] in_pixel;
    logic             in_ready;
    logic             win_valid;
    logic             win_ready;
    logic [PIX_W-1:0] sw_pixels1, sw_pixels2, sw_pixels3;
    logic [PIX_W-1:0] sw_pixels4, sw_pixels5, sw_pixels6;
    logic [PIX_W-1:0] sw_pixels7, sw_pixels8, sw_pixels9;
    logic             frame_done;

    modport master (
        output in_valid, in_sof, in_pixel, win_ready,
        input  in_ready, win_valid, frame_done,
        input  sw_pixels1, sw_pixels2, sw_pixels3, sw_pixels4, sw_pixels5,
        input  sw_pixels6, sw_pixels7, sw_pixels8, sw_pixels9
    );

    modport slave (
        input  in_valid, in_sof, in_pixel, win_ready,
        output in_ready, win_valid, frame_done,
        output sw_pixels1, sw_pixels2, sw_pixels3, sw_pixels4, sw_pixels5,
        output sw_pixels6, sw_pixels7, sw_pixels8, sw_pixels9
    );
endinterface

// File: rtl/sliding_window_gen_line_buffer.sv
// One image line of pixel storage: synchronous write, asynchronous read at the same address.
module line_buffer #(
    parameter int DEPTH = 64,
    parameter int PIX_W = 8,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);
    logic [PIX_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/sliding_window_gen.sv
// Raster-to-3x3 window generator with two line buffers and a single registered output stage.
// Optional build macro WIN_COUNT_EN adds the win_count output.
module sliding_window_gen
    import sw_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sliding_window_gen_if.slave  bus
`ifdef WIN_COUNT_EN
    ,
    output logic [$clog2(IMG_W*IMG_H):0] win_count
`endif
);
    localparam int CW = idx_w(IMG_W);
    localparam int RW = idx_w(IMG_H);

    state_e            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              win_valid_q, win_valid_d;
    logic              frame_done_q, frame_done_d;
    logic [PIX_W-1:0]  win_q [TL:BR];
    logic [PIX_W-1:0]  win_d [TL:BR];

    logic              in_ready;
    logic              acc, sof_acc, take, emit, last;
    logic [CW-1:0]     eff_col;
    logic [RW-1:0]     eff_row;
    logic [PIX_W-1:0]  lb0_rd, lb1_rd;

    assign in_ready = !win_valid_q || bus.win_ready;
    assign acc      = bus.in_valid && in_ready;
    assign sof_acc  = acc && bus.in_sof;
    // A start-of-frame pixel is always (0,0), whatever the counters held before.
    assign eff_col  = sof_acc ? '0 : col_q;
    assign eff_row  = sof_acc ? '0 : row_q;
    assign take     = acc && (sof_acc || (state_q != IDLE));
    assign emit     = take && (eff_row >= RW'(2)) && (eff_col >= CW'(2));
    assign last     = take && (eff_row == RW'(IMG_H-1)) && (eff_col == CW'(IMG_W-1));

    line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W), .AW(CW)) u_lb0 (
        .clk   (clk),
        .we    (take),
        .addr  (eff_col),
        .wdata (bus.in_pixel),
        .rdata (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W), .AW(CW)) u_lb1 (
        .clk   (clk),
        .we    (take),
        .addr  (eff_col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        win_valid_d  = win_valid_q && !bus.win_ready;
        frame_done_d = 1'b0;
        win_d        = win_q;

        if (take) begin
            if (eff_col == CW'(IMG_W-1)) begin
                col_d = '0;
                row_d = eff_row + RW'(1);
            end else begin
                col_d = eff_col + CW'(1);
                row_d = eff_row;
            end

            if (last) begin
                col_d        = '0;
                row_d        = '0;
                state_d      = IDLE;
                frame_done_d = 1'b1;
            end else if (row_d >= RW'(2)) begin
                state_d = RUN;
            end else begin
                state_d = FILL;
            end

            // Shift left one column; the new right column is {row-2, row-1, row}.
            for (int r = 0; r < 3; r++) begin
                win_d[TL + 3*r]     = win_q[TL + 3*r + 1];
                win_d[TL + 3*r + 1] = win_q[TL + 3*r + 2];
            end
            win_d[TL + 2] = lb1_rd;
            win_d[TL + 5] = lb0_rd;
            win_d[BR]     = bus.in_pixel;

            if (emit) begin
                win_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = TL; i <= BR; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

`ifdef WIN_COUNT_EN
    logic [$clog2(IMG_W*IMG_H):0] win_count_q, win_count_d;

    always_comb begin
        win_count_d = win_count_q;
        if (sof_acc) begin
            win_count_d = '0;
        end else if (win_valid_q && bus.win_ready) begin
            win_count_d = win_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_count_q <= '0;
        end else begin
            win_count_q <= win_count_d;
        end
    end

    assign win_count = win_count_q;
`endif

    assign bus.in_ready   = in_ready;
    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.sw_pixels1 = win_q[TL];
    assign bus.sw_pixels2 = win_q[TL + 1];
    assign bus.sw_pixels3 = win_q[TL + 2];
    assign bus.sw_pixels4 = win_q[TL + 3];
    assign bus.sw_pixels5 = win_q[C];
    assign bus.sw_pixels6 = win_q[C + 1];
    assign bus.sw_pixels7 = win_q[C + 2];
    assign bus.sw_pixels8 = win_q[C + 3];
    assign bus.sw_pixels9 = win_q[BR];

endmodule

// File: tb/tb_sliding_window_gen.sv
// Directed self-checking bench for sliding_window_gen on a 4x4 image.
module tb_sliding_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sliding_window_gen_if #(.PIX_W(8)) bus ();

`ifdef WIN_COUNT_EN
    logic [4:0] win_count;
`endif

    sliding_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef WIN_COUNT_EN
        ,
        .win_count (win_count)
`endif
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected window centred on (r,c) of a frame whose pixel (y,x) = base + y*W + x.
    function automatic logic [71:0] expw(input int base, input int r, input int c);
        logic [71:0] v;
        for (int k = 0; k < 9; k++) begin
            v[71 - 8*k -: 8] = 8'(base + (r - 1 + k / 3) * W + (c - 1 + k % 3));
        end
        return v;
    endfunction

    function automatic logic [71:0] obsw();
        return {bus.sw_pixels1, bus.sw_pixels2, bus.sw_pixels3,
                bus.sw_pixels4, bus.sw_pixels5, bus.sw_pixels6,
                bus.sw_pixels7, bus.sw_pixels8, bus.sw_pixels9};
    endfunction

    task automatic push(input int pix, input logic sof);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_pixel = 8'(pix);
        bus.in_sof   = sof;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 50) begin
                chk("push_timeout", 72'(bus.in_ready), 72'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic run_frame(input int base, input int stall_win);
        int nobs = 0;
        int ndone = 0;
        for (int i = 0; i < W * H; i++) begin
            int  r = i / W;
            int  c = i % W;
            logic ev = (r >= 2) && (c >= 2);
            push(base + i, i == 0);
            if (bus.win_valid) nobs++;
            if (bus.frame_done) ndone++;
            chk("win_valid", 72'(bus.win_valid), 72'(ev));
            chk("frame_done", 72'(bus.frame_done), 72'(i == W * H - 1));
            if (ev) chk("window", obsw(), expw(base, r - 1, c - 1));
`ifdef WIN_COUNT_EN
            if (i == 0) chk("win_count_clear", 72'(win_count), 72'(0));
`endif
            if (stall_win > 0 && ev && nobs == stall_win && i < W * H - 1) begin
                bus.win_ready = 1'b0;
                bus.in_valid  = 1'b1;
                bus.in_pixel  = 8'(base + i + 1);
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 72'(bus.in_ready), 72'(0));
                    chk("stall_valid", 72'(bus.win_valid), 72'(1));
                    chk("stall_window", obsw(), expw(base, r - 1, c - 1));
                end
                @(posedge clk);
                #1;
                bus.win_ready = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("post_frame_done", 72'(bus.frame_done), 72'(0));
        chk("post_win_valid", 72'(bus.win_valid), 72'(0));
        chk("window_count", 72'(nobs), 72'(4));
        chk("frame_done_count", 72'(ndone), 72'(1));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_pixel  = '0;
        bus.win_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_win_valid", 72'(bus.win_valid), 72'(0));
        chk("reset_frame_done", 72'(bus.frame_done), 72'(0));
        chk("reset_in_ready", 72'(bus.in_ready), 72'(1));
        chk("reset_window", obsw(), 72'(0));

        // Plain frame at full throughput.
        run_frame(0, 0);
`ifdef WIN_COUNT_EN
        chk("win_count_final", 72'(win_count), 72'(4));
        repeat (2) @(posedge clk);
        #1;
        chk("win_count_hold", 72'(win_count), 72'(4));
`endif

        // Pixels without start-of-frame in IDLE are dropped.
        for (int i = 0; i < 6; i++) begin
            push(i, 1'b0);
            chk("idle_win_valid", 72'(bus.win_valid), 72'(0));
            chk("idle_frame_done", 72'(bus.frame_done), 72'(0));
        end
        run_frame(0, 0);

        // Back-pressure on the second window.
        run_frame(0, 2);

        // Frame A aborted by start-of-frame at its pixel 9, then frame B.
        for (int i = 0; i < 9; i++) begin
            push(i, i == 0);
            chk("abort_win_valid", 72'(bus.win_valid), 72'(0));
            chk("abort_frame_done", 72'(bus.frame_done), 72'(0));
        end
        run_frame(100, 0);

        // Reset while a window is valid in RUN.
        for (int i = 0; i <= 10; i++) begin
            push(i, i == 0);
        end
        chk("pre_rst_valid", 72'(bus.win_valid), 72'(1));
        bus.win_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.win_ready = 1'b1;
        chk("rst_win_valid", 72'(bus.win_valid), 72'(0));
        chk("rst_window", obsw(), 72'(0));
        chk("rst_in_ready", 72'(bus.in_ready), 72'(1));
        chk("rst_frame_done", 72'(bus.frame_done), 72'(0));
        run_frame(0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sliding_window_gen.md
Name: sliding_window_gen

Overview:
- Raster-to-3x3 window generator that feeds the 3x3 neighbourhood filter.
- Accepts one PIX_W-bit pixel per handshake in row-major order.
- Stores the two previous image lines in line buffers and presents a registered 3x3 window (sw_pixels1..9).
- win_valid drives the filter's en input; one window is emitted per interior pixel.

Parameters:
- IMG_W, 64: image width in pixels (>=3)
- IMG_H, 64: image height in lines (>=3)
- PIX_W, 8: pixel width in bits

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  input pixel valid
- in_sof  in  1  qualifies in_pixel as frame pixel (0,0)
- in_pixel  in  PIX_W  input pixel
- in_ready  out  1  generator can accept a pixel
- win_valid  out  1  window valid (to filter en)
- win_ready  in  1  downstream accepts window
- sw_pixels1..sw_pixels9  out  PIX_W each  window, row-major; 1=top-left, 5=centre, 9=bottom-right
- frame_done  out  1  one-cycle pulse after last pixel of a frame is accepted

Behaviour:
- Accept: in_valid & in_ready. in_ready = !win_valid | win_ready (single output stage, no bubble under full throughput).
- Counters: col 0..IMG_W-1, row 0..IMG_H-1. Advance per accepted pixel only; col wraps to 0 and row increments at IMG_W-1.
- Line buffers: two IMG_W-deep buffers, lb0 = line row-1 and lb1 = line row-2, read/written at address col.
  - On accept: lb1[col] <= lb0[col]; lb0[col] <= in_pixel.
- Window shift register: 3x3 registers shift left one column per accept. The new right column is {lb1[col], lb0[col], in_pixel} (top, mid, bottom).
- FSM states:
  - IDLE: accepted pixels without in_sof are discarded (in_ready=1 while win_valid=0). An accept with in_sof sets col=1, row=0 and goes to FILL.
  - FILL: row<2; no windows emitted. Go to RUN when row becomes 2.
  - RUN: an accept at col>=2 loads the output window on the next edge and sets win_valid=1. That window covers rows row-2..row and cols col-2..col. Accepts at col<2 emit nothing.
  - After accepting (IMG_H-1, IMG_W-1): emit the last window, pulse frame_done for 1 cycle, go to IDLE.
- Latency: window valid 1 cycle after accepting its bottom-right pixel.
- win_valid and sw_pixels hold stable while win_valid & !win_ready.
- Windows per frame: (IMG_W-2)*(IMG_H-2), in raster order of the centre pixel.
- in_sof accepted in FILL/RUN:
  - aborts the current frame; that pixel becomes (0,0); state goes to FILL.
  - a pending win_valid still completes its handshake.
  - no frame_done for the aborted frame.
- Simultaneous win_ready and a new accept: the old window is consumed and the new one loaded in the same edge.
- Reset (any time, including mid-frame or mid-stall):
  - state=IDLE, row=col=0, win_valid=0, frame_done=0, sw_pixels1..9=0.
  - line buffer contents are don't-care.
- in_valid=0 cycles freeze all state.

Optional Feature:
- Macro WIN_COUNT_EN.
- Defined: adds output win_count, width $clog2(IMG_W*IMG_H)+1.
  - cleared by reset and by each accepted in_sof.
  - increments on each win_valid & win_ready.
  - holds its final value after frame_done.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package sw_pkg holds:
  - state enum {IDLE, FILL, RUN};
  - localparams COL_W=$clog2(IMG_W) and ROW_W=$clog2(IMG_H);
  - window index constants TL=1, C=5, BR=9.
- One sub-module, line_buffer: single-port-read/single-port-write IMG_W x PIX_W memory with registered-free async read. Instantiated twice.

Test Plan:
- IMG_W=4, IMG_H=4, pixel=row*4+col, win_ready=1, continuous in_valid:
  - first win_valid one cycle after pixel 10 accepted;
  - window = 0,1,2,4,5,6,8,9,10;
  - exactly 4 windows, last = 5,6,7,9,10,11,13,14,15;
  - frame_done pulses once.
- Same stimulus, win_ready low for 3 cycles on the 2nd window (centre 6): in_ready=0, window 1,2,3,5,6,7,9,10,11 held stable, no pixel lost, remaining windows correct.
- Pixels 0..5 sent with in_sof=0 from IDLE, then a full frame: the first 6 are discarded and output matches scenario 1.
- in_sof reasserted at pixel 9 of frame A, then full frame B (values 100+index): no frame_done for A; windows match B only (first = 100,101,102,104,105,106,108,109,110).
- rst asserted one cycle mid-RUN with win_valid=1: next cycle win_valid=0, sw_pixels=0, in_ready=1; the following full frame is correct.
- WIN_COUNT_EN defined, scenario 1: win_count=4 after frame_done; resets to 0 on the next in_sof.
